// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator CPU: opcodes, FSM states, ALU ops and skip codes.
package acc_cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP      = 4'h0,
        OP_LOAD     = 4'h1,
        OP_STORE    = 4'h2,
        OP_ADD      = 4'h3,
        OP_SUBT     = 4'h4,
        OP_HALT     = 4'h7,
        OP_SKIPCOND = 4'h8,
        OP_JUMP     = 4'h9,
        OP_CLEAR    = 4'hA,
        OP_ADDI     = 4'hB
    } opcode_e;

    typedef enum logic [2:0] {
        ST_HALT,
        ST_F0,
        ST_F1,
        ST_F2,
        ST_EX0,
        ST_EX1
    } state_e;

    typedef enum logic [1:0] {
        ALU_PASS,
        ALU_ADD,
        ALU_SUB
    } alu_op_e;

    localparam logic [1:0] SK_NEG   = 2'b00;
    localparam logic [1:0] SK_ZERO  = 2'b01;
    localparam logic [1:0] SK_POS   = 2'b10;
    localparam logic [1:0] SK_NEVER = 2'b11;

    function automatic logic skip_taken(input logic [1:0] cond, input logic neg, input logic zero);
        case (cond)
            SK_NEG:  return neg;
            SK_ZERO: return zero;
            SK_POS:  return !neg && !zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// Single-port synchronous RAM port between the core (master) and the memory (slave).
interface acc_cpu_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;

    modport master (output mem_addr, mem_wdata, mem_cs, mem_we, mem_oe, input mem_rdata);
    modport slave  (input mem_addr, mem_wdata, mem_cs, mem_we, mem_oe, output mem_rdata);
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator ALU: pass/add/sub plus sign and zero flags of the accumulator.
module acc_cpu_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  alu_op_e                       op,
    input  logic signed [DATA_WIDTH-1:0]  a,
    input  logic signed [DATA_WIDTH-1:0]  b,
    output logic signed [DATA_WIDTH-1:0]  y,
    output logic                          neg,
    output logic                          zero
);
    always_comb begin
        y = b;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            default: y = b;
        endcase
    end

    assign neg  = a[DATA_WIDTH-1];
    assign zero = (a == '0);
endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: two-word fetch, execute against a synchronous RAM, halt/start handshake.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    acc_cpu_if.master             mem,
    output logic                  halted,
    output logic                  illegal,
    output logic [DATA_WIDTH-1:0] ac_out,
    output logic [ADDR_WIDTH-1:0] pc_out
);
    if (DATA_WIDTH < 8 || ADDR_WIDTH > DATA_WIDTH) begin : g_bad_params
        $error("acc_cpu_core: need DATA_WIDTH >= 8 and ADDR_WIDTH <= DATA_WIDTH");
    end

    state_e                        state, state_nxt;
    logic [ADDR_WIDTH-1:0]         pc, pc_nxt;
    logic [DATA_WIDTH-1:0]         ira, ira_nxt, irb, irb_nxt;
    logic signed [DATA_WIDTH-1:0]  ac, ac_nxt, alu_b, alu_y;
    logic                          illegal_q, illegal_nxt;
    logic [3:0]                    opc;
    logic [ADDR_WIDTH-1:0]         ea;
    alu_op_e                       alu_op;
    logic                          ac_neg, ac_zero;
    logic [ADDR_WIDTH-1:0]         addr_c;
    logic                          cs_c, we_c;
    logic                          unused_ira_bits;

    assign opc             = ira[DATA_WIDTH-1 -: 4];
    assign ea              = irb[ADDR_WIDTH-1:0];
    assign unused_ira_bits = ^ira[DATA_WIDTH-5:2];

    // Memory operand arrives in EX1; ADDI uses the operand word itself.
    assign alu_b = (state == ST_EX1) ? mem.mem_rdata : irb;

    always_comb begin
        alu_op = ALU_ADD;
        case (opc)
            OP_LOAD: alu_op = ALU_PASS;
            OP_SUBT: alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
        endcase
    end

    acc_cpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op   (alu_op),
        .a    (ac),
        .b    (alu_b),
        .y    (alu_y),
        .neg  (ac_neg),
        .zero (ac_zero)
    );

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ira_nxt     = ira;
        irb_nxt     = irb;
        ac_nxt      = ac;
        illegal_nxt = illegal_q;
        case (state)
            ST_HALT: if (start) state_nxt = ST_F0;
            ST_F0:   state_nxt = ST_F1;
            ST_F1: begin
                ira_nxt   = mem.mem_rdata;
                pc_nxt    = pc + 1'b1;
                state_nxt = ST_F2;
            end
            ST_F2: begin
                irb_nxt   = mem.mem_rdata;
                pc_nxt    = pc + 1'b1;
                state_nxt = ST_EX0;
            end
            ST_EX0: begin
                state_nxt = ST_F0;
                case (opc)
                    OP_LOAD, OP_ADD, OP_SUBT: state_nxt = ST_EX1;
                    OP_NOP, OP_STORE:         ;
                    OP_HALT:                  state_nxt = ST_HALT;
                    OP_SKIPCOND: if (skip_taken(ira[1:0], ac_neg, ac_zero)) pc_nxt = pc + ADDR_WIDTH'(2);
                    OP_JUMP:                  pc_nxt = ea;
                    OP_CLEAR:                 ac_nxt = '0;
                    OP_ADDI:                  ac_nxt = alu_y;
                    default: begin
                        illegal_nxt = 1'b1;
                        state_nxt   = ST_HALT;
                    end
                endcase
            end
            ST_EX1: begin
                ac_nxt    = alu_y;
                state_nxt = ST_F0;
            end
            default: state_nxt = ST_HALT;
        endcase
    end

    // Memory controls depend on registered state only, never on mem_rdata.
    always_comb begin
        addr_c = pc;
        cs_c   = 1'b0;
        we_c   = 1'b0;
        case (state)
            ST_F0: cs_c = 1'b1;
            ST_F1: begin
                cs_c   = 1'b1;
                addr_c = pc + 1'b1;
            end
            ST_EX0: begin
                addr_c = ea;
                case (opc)
                    OP_LOAD, OP_ADD, OP_SUBT: cs_c = 1'b1;
                    OP_STORE: begin
                        cs_c = 1'b1;
                        we_c = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_EX1:  addr_c = ea;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HALT;
            pc        <= ADDR_WIDTH'(RESET_PC);
            ira       <= '0;
            irb       <= '0;
            ac        <= '0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ira       <= ira_nxt;
            irb       <= irb_nxt;
            ac        <= ac_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    assign mem.mem_addr  = addr_c;
    assign mem.mem_wdata = ac;
    assign mem.mem_cs    = cs_c;
    assign mem.mem_we    = we_c;
    assign mem.mem_oe    = cs_c & ~we_c;
    assign halted        = (state == ST_HALT);
    assign illegal       = illegal_q;
    assign ac_out        = ac;
    assign pc_out        = pc;
endmodule
